instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage sitting directly upstream of `instructionMem`: owns the program counter, presents it to instruction memory, and captures the returned 32-bit word. The word holds four 8-bit VLIW slot instructions. Captured words, tagged with their PC, go into a small FIFO that feeds decode over a valid/ready handshake. The block also handles memory misses, back-pressure from decode, and branch redirects from execute.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC after reset; bits [1:0] must be 0.
- `BUF_DEPTH`, 4: FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `imemPC`  out  32  address to instruction memory; registered.
- `imemHit`  in  1  memory has a valid word for `imemPC` this cycle.
- `imemWord`  in  32  instruction word for `imemPC`; sampled only when `imemHit`=1.
- `redirect`  in  1  branch taken; 1-cycle pulse.
- `redirectPC`  in  32  branch target; bits [1:0] ignored.
- `decReady`  in  1  decode accepts the head entry.
- `decValid`  out  1  head entry valid.
- `decWord`  out  32  head entry instruction word.
- `decPC`  out  32  head entry PC.
- `fetchCount`  out  16  words pushed (only with `FETCH_PERF_EN`).
- `missCount`  out  16  cycles with `imemHit`=0 in FETCH or MISS (only with `FETCH_PERF_EN`).

## Operation
- Reset values: `imemPC`=`RESET_PC`, FIFO empty, `decValid`=0, `decWord`=0, `decPC`=0, counters 0, state FETCH.
- Pop: `decValid && decReady`. `decValid` = (count != 0). `decWord` and `decPC` always show the head entry. When empty, they hold the last popped value, or 0 after reset.
- Push condition: state FETCH or MISS, `imemHit`=1, `redirect`=0, and either count < `BUF_DEPTH` or a pop in the same cycle.
- On push: the entry {`imemPC`, `imemWord`} is written at the tail, and `imemPC` <= `imemPC`+4.
- PC wraps from 32'hFFFF_FFFC to 0 with no flag.
- FSM states:
  - FETCH: hit and push goes to FETCH. Hit but no push (FIFO full, no pop) goes to STALL. Miss goes to MISS.
  - MISS: `imemPC` held. Hit and push goes to FETCH. Hit with FIFO full goes to STALL. Miss stays in MISS.
  - STALL: no push, `imemPC` held. Goes to FETCH in the cycle after count drops below `BUF_DEPTH`. The hit in the STALL cycle itself is ignored.
- Redirect has the highest priority, in any state:
  - FIFO is flushed to count 0.
  - `imemPC` <= {`redirectPC`[31:2], 2'b00}.
  - State goes to FETCH.
  - Any hit that cycle is discarded.
- Redirect and pop in the same cycle: the popped entry counts as accepted by decode, and all remaining entries are flushed.
- Push and pop together when count == `BUF_DEPTH`: legal; count is unchanged.
- Read and write pointers wrap modulo `BUF_DEPTH`. count ranges 0..`BUF_DEPTH`.

## Timing
- `imemPC` changes only on a rising edge. Memory returns `imemHit`/`imemWord` within the same cycle, sampled at the next rising edge.
- Fetch-to-decode latency: a word hit in cycle N is visible on `decValid`/`decWord` in cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle when hitting and decode is always ready.
- Redirect latency:
  - `imemPC` = target in the cycle after `redirect`.
  - `decValid`=0 in that cycle.
  - The first target word is visible on `decValid` two cycles after `redirect`.
- Reset mid-operation: outputs take their reset values asynchronously, without waiting for `clk`. The first fetch occurs at the first rising edge after `reset` returns to 1.

## Configuration
- `FETCH_PERF_EN` defined:
  - `fetchCount` increments on each push.
  - `missCount` increments on each cycle in FETCH or MISS with `imemHit`=0 and `redirect`=0.
  - Both saturate at 16'hFFFF and clear only on reset.
- `FETCH_PERF_EN` undefined: counter logic is absent and both ports are tied to 16'h0000.
- Fetch behaviour is identical either way.

## Test plan
- Reset then stream: `RESET_PC`=0, `imemHit`=1, `decReady`=1 -> `decPC` = 0,4,8,… on consecutive cycles starting the cycle after reset release; `decWord` matches memory.
- Back-pressure: `decReady`=0 for 10 cycles, `BUF_DEPTH`=4 -> exactly 4 pushes with `imemPC` stuck at 16 and state STALL. After `decReady`=1, entries 0,4,8,12 pop in order, then 16 follows with no gap beyond one cycle.
- Miss: `imemHit`=0 for 3 cycles at PC 8 -> `imemPC` holds 8 and there are no pushes. Next entry has `decPC`=8; `missCount`=3 with `FETCH_PERF_EN`.
- Redirect with full FIFO and simultaneous pop: `redirectPC`=32'h0000_0103 -> the popped entry is accepted, `decValid`=0 next cycle, `imemPC`=32'h100, and the first new `decPC`=32'h100.
- Wrap: redirect to 32'hFFFF_FFFC with hits -> `decPC` sequence FFFF_FFFC, 0000_0000.
- Async reset mid-stream with 3 entries buffered -> `decValid`=0 and `imemPC`=`RESET_PC` before the next clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage in front of instruction memory. Owns the PC, presents it on
//   imemPC, captures the returned 32-bit VLIW word (four 8-bit slots) and
//   queues {PC, word} in a small FIFO feeding decode over valid/ready.
//   Handles memory misses, decode back-pressure and branch redirects.
//
// Parameters
//   RESET_PC   PC after reset (bits [1:0] must be 0)
//   BUF_DEPTH  FIFO entries, power of two, 2..16
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   imemPC      registered fetch address to instruction memory
//   imemHit     memory holds a valid word for imemPC this cycle
//   imemWord    instruction word for imemPC
//   redirect    branch-taken pulse from execute
//   redirectPC  branch target (bits [1:0] ignored)
//   decReady    decode accepts the head entry
//   decValid    head entry valid
//   decWord     head entry instruction word
//   decPC       head entry PC
//   fetchCount  saturating count of pushed words
//   missCount   saturating count of miss cycles in FETCH/MISS
//
// Optional feature: define FETCH_PERF_EN to build the two performance
// counters; otherwise fetchCount and missCount are tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_FETCH | presenting imemPC, pushing each hit word
// S_MISS  | memory missed, imemPC held until the word arrives
// S_STALL | FIFO full, imemPC held, waiting for decode to pop
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemPC,
  input  logic        imemHit,
  input  logic [31:0] imemWord,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  input  logic        decReady,
  output logic        decValid,
  output logic [31:0] decWord,
  output logic [31:0] decPC,
  output logic [15:0] fetchCount,
  output logic [15:0] missCount
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_FETCH, S_MISS, S_STALL} state_t;

  state_t           state;
  logic [31:0]      buf_word [BUF_DEPTH];
  logic [31:0]      buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0] count, cnt_after_pop, count_nxt;
  logic             fetching, pop, push;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^redirectPC[1:0];

  assign decValid = (count != '0);

  always_comb begin
    fetching      = (state == S_FETCH) || (state == S_MISS);
    pop           = decValid && decReady;
    push          = fetching && imemHit && !redirect && ((count < DEPTH_C) || pop);
    cnt_after_pop = count - CNT_W'(pop);
    count_nxt     = cnt_after_pop + CNT_W'(push);
    rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_word[wr_ptr] <= imemWord;
      buf_pc[wr_ptr]   <= imemPC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      imemPC  <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      decWord <= '0;
      decPC   <= '0;
    end else if (redirect) begin
      // Flush wins over everything; a same-cycle pop has already been taken.
      state  <= S_FETCH;
      imemPC <= {redirectPC[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count  <= count_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        imemPC <= imemPC + 32'd4;
      end
      // Head registers track the next head; when the FIFO drains they keep
      // the last shown entry. A push into an otherwise empty FIFO becomes
      // the head directly since storage is not written until this edge.
      if (count_nxt != '0) begin
        if (push && (cnt_after_pop == '0)) begin
          decWord <= imemWord;
          decPC   <= imemPC;
        end else begin
          decWord <= buf_word[rd_ptr_nxt];
          decPC   <= buf_pc[rd_ptr_nxt];
        end
      end
      case (state)
        S_FETCH, S_MISS: begin
          if (!imemHit)  state <= S_MISS;
          else if (push) state <= S_FETCH;
          else           state <= S_STALL;
        end
        S_STALL: state <= (count_nxt < DEPTH_C) ? S_FETCH : S_STALL;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchCount <= '0;
      missCount  <= '0;
    end else begin
      if (push && (fetchCount != 16'hFFFF))
        fetchCount <= fetchCount + 16'd1;
      if (fetching && !imemHit && !redirect && (missCount != 16'hFFFF))
        missCount <= missCount + 16'd1;
    end
  end
`else
  assign fetchCount = 16'h0000;
  assign missCount  = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] imemPC;
  logic        imemHit;
  logic [31:0] imemWord;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        decReady;
  logic        decValid;
  logic [31:0] decWord;
  logic [31:0] decPC;
  logic [15:0] fetchCount;
  logic [15:0] missCount;

  int n_total = 0;
  int n_pass  = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  instruction_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .imemPC(imemPC), .imemHit(imemHit),
    .imemWord(imemWord), .redirect(redirect), .redirectPC(redirectPC),
    .decReady(decReady), .decValid(decValid), .decWord(decWord),
    .decPC(decPC), .fetchCount(fetchCount), .missCount(missCount)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hC3A5, ~pc[31:16]};
  endfunction

  assign imemWord = mem_word(imemPC);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; imemHit = 1'b0; redirect = 1'b0; redirectPC = '0; decReady = 1'b0;
    #1;
    chk("rst_pc", imemPC, 32'h0);
    chk("rst_valid", {31'b0, decValid}, 32'h0);
    chk("rst_word", decWord, 32'h0);
    chk("rst_decpc", decPC, 32'h0);
    chk("rst_fcnt", {16'h0, fetchCount}, 32'h0);
    chk("rst_mcnt", {16'h0, missCount}, 32'h0);

    // stream from reset
    imemHit = 1'b1; decReady = 1'b1;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("str_valid", {31'b0, decValid}, 32'h1);
      chk("str_pc", decPC, 32'(4 * i));
      chk("str_word", decWord, mem_word(32'(4 * i)));
      chk("str_imem", imemPC, 32'(4 * i + 4));
    end

    // buffer 3 entries, then async reset between edges
    decReady = 1'b0;
    step(); step();
    chk("buf3_imem", imemPC, 32'd32);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, decValid}, 32'h0);
    chk("arst_imem", imemPC, 32'h0);
    chk("arst_decpc", decPC, 32'h0);
    chk("arst_word", decWord, 32'h0);

    // back-pressure
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bp_imem4", imemPC, 32'd16);
    for (int i = 0; i < 6; i++) step();
    chk("bp_imem10", imemPC, 32'd16);
    chk("bp_valid", {31'b0, decValid}, 32'h1);
    chk("bp_head", decPC, 32'h0);
    chk("bp_word", decWord, mem_word(32'h0));
    chk("bp_fcnt", {16'h0, fetchCount}, PERF ? 32'd4 : 32'd0);
    decReady = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bp_valid_drain", {31'b0, decValid}, 32'h1);
      chk("bp_pop_pc", decPC, 32'(4 * k));
    end

    // miss at PC 8
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("ms_pc0", decPC, 32'h0);
    step();
    chk("ms_imem8", imemPC, 32'd8);
    imemHit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ms_hold", imemPC, 32'd8);
      chk("ms_empty", {31'b0, decValid}, 32'h0);
    end
    chk("ms_lastpop", decPC, 32'd4);
    imemHit = 1'b1;
    step();
    chk("ms_valid", {31'b0, decValid}, 32'h1);
    chk("ms_pc8", decPC, 32'd8);
    chk("ms_word", decWord, mem_word(32'd8));
    chk("ms_imem12", imemPC, 32'd12);
    chk("ms_mcnt", {16'h0, missCount}, PERF ? 32'd3 : 32'd0);

    // redirect with full FIFO and simultaneous pop
    decReady = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("rd_full_imem", imemPC, 32'd24);
    chk("rd_head", decPC, 32'd8);
    decReady = 1'b1; redirect = 1'b1; redirectPC = 32'h0000_0103;
    step();
    redirect = 1'b0;
    chk("rd_valid0", {31'b0, decValid}, 32'h0);
    chk("rd_imem", imemPC, 32'h100);
    step();
    chk("rd_valid1", {31'b0, decValid}, 32'h1);
    chk("rd_pc", decPC, 32'h100);
    chk("rd_word", decWord, mem_word(32'h100));
    chk("rd_fcnt", {16'h0, fetchCount}, PERF ? 32'd7 : 32'd0);

    // PC wrap
    redirect = 1'b1; redirectPC = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wr_valid0", {31'b0, decValid}, 32'h0);
    chk("wr_imem", imemPC, 32'hFFFF_FFFC);
    step();
    chk("wr_pc_top", decPC, 32'hFFFF_FFFC);
    chk("wr_imem0", imemPC, 32'h0);
    step();
    chk("wr_pc0", decPC, 32'h0);
    chk("wr_word0", decWord, mem_word(32'h0));
    chk("wr_imem4", imemPC, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
